// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared RV32I pipeline codes for the writeback stage
package pipe_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      WBSEL_ALU  = 2'b00,
      WBSEL_LOAD = 2'b01,
      WBSEL_PC4  = 2'b10,
      WBSEL_RSVD = 2'b11
   } wbsel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM-to-WB handoff and register file write port bundle
interface writeback_stage_if;
   import pipe_pkg::*;

   logic            stall;
   logic            flush;
   logic            mem_valid;
   logic [4:0]      mem_rd;
   logic            mem_regwrite;
   logic [1:0]      mem_wbsel;
   logic [2:0]      mem_funct3;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_load_data;
   logic [XLEN-1:0] mem_pc_plus4;

   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_writedata;
   logic            wb_regwrite;
   logic            wb_valid;

   modport master (
      output stall, flush, mem_valid, mem_rd, mem_regwrite, mem_wbsel,
             mem_funct3, mem_alu_result, mem_load_data, mem_pc_plus4,
      input  wb_rd, wb_writedata, wb_regwrite, wb_valid
   );

   modport slave (
      input  stall, flush, mem_valid, mem_rd, mem_regwrite, mem_wbsel,
             mem_funct3, mem_alu_result, mem_load_data, mem_pc_plus4,
      output wb_rd, wb_writedata, wb_regwrite, wb_valid
   );

endinterface

// File: rtl/writeback_stage_load_align.sv
// rtl/writeback_stage_load_align.sv - picks the addressed byte/halfword from a raw word and extends it
module load_align
   import pipe_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Little-endian lanes; halfword selection looks only at off[1].
   always_comb begin
      lane_b = 8'h00;
      case (off)
         2'd0: lane_b = raw[7:0];
         2'd1: lane_b = raw[15:8];
         2'd2: lane_b = raw[23:16];
         2'd3: lane_b = raw[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = off[1] ? raw[31:16] : raw[15:0];
   end

   always_comb begin
      data = '0;
      case (funct3)
         F3_LB:   data = {{24{lane_b[7]}}, lane_b};
         F3_LBU:  data = {24'h000000, lane_b};
         F3_LH:   data = {{16{lane_h[15]}}, lane_h};
         F3_LHU:  data = {16'h0000, lane_h};
         F3_LW:   data = raw;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, result select and retire counter
module writeback_stage
   import pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   writeback_stage_if.slave wb,
   output logic [CNT_W-1:0] retire_count
);

   logic             valid_q;
   logic             regwrite_q;
   logic [4:0]       rd_q;
   logic [1:0]       wbsel_q;
   logic [2:0]       funct3_q;
   logic [XLEN-1:0]  alu_q;
   logic [XLEN-1:0]  ld_q;
   logic [XLEN-1:0]  pc4_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  load_val;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         rd_q       <= '0;
         wbsel_q    <= '0;
         funct3_q   <= '0;
         alu_q      <= '0;
         ld_q       <= '0;
         pc4_q      <= '0;
      end else if (wb.flush) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
      end else if (!wb.stall) begin
         valid_q    <= wb.mem_valid;
         regwrite_q <= wb.mem_regwrite;
         rd_q       <= wb.mem_rd;
         wbsel_q    <= wb.mem_wbsel;
         funct3_q   <= wb.mem_funct3;
         alu_q      <= wb.mem_alu_result;
         ld_q       <= wb.mem_load_data;
         pc4_q      <= wb.mem_pc_plus4;
      end
   end

   // Counted on entry only, so a stalled instruction is never counted twice.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!wb.flush && !wb.stall && wb.mem_valid) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   load_align u_load_align (
      .funct3 (funct3_q),
      .off    (alu_q[1:0]),
      .raw    (ld_q),
      .data   (load_val)
   );

   always_comb begin
      wb.wb_writedata = '0;
      case (wbsel_q)
         WBSEL_ALU:  wb.wb_writedata = alu_q;
         WBSEL_LOAD: wb.wb_writedata = load_val;
         WBSEL_PC4:  wb.wb_writedata = pc4_q;
         default:    wb.wb_writedata = '0;
      endcase
   end

   // x0 writes are dropped here rather than trusting the register file.
   assign wb.wb_regwrite = valid_q & regwrite_q & (rd_q != 5'd0);
   assign wb.wb_rd       = rd_q;
   assign wb.wb_valid    = valid_q;
   assign retire_count   = cnt_q;

endmodule
